// File: rtl/hack_fetch_pkg.sv
// rtl/hack_fetch_pkg.sv - shared widths, types and helpers for the Hack instruction fetch stage
package hack_fetch_pkg;

    localparam int PC_W   = 15;
    localparam int WORD_W = 16;

    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [WORD_W-1:0] word_t;

    localparam pc_t RESET_PC = '0;

    typedef struct packed {
        word_t data;
        pc_t   pc;
    } fetch_entry_t;

    // 15-bit increment; 0x7FFF rolls over to 0x0000 with no carry out
    function automatic pc_t pc_next(input pc_t pc);
        return pc + pc_t'(1);
    endfunction

endpackage

// File: rtl/hack_fetch_if.sv
// rtl/hack_fetch_if.sv - jump, ROM and instruction-stream signals of the fetch stage
interface hack_fetch_if
    import hack_fetch_pkg::*;
    ;

    logic              jump;
    logic [WORD_W-1:0] jump_addr;
    pc_t               rom_addr;
    word_t             rom_data;
    word_t             instr;
    pc_t               instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    modport master (
        input  jump,
        input  jump_addr,
        input  rom_data,
        input  instr_ready,
        output rom_addr,
        output instr,
        output instr_pc,
        output instr_valid
    );

    modport slave (
        output jump,
        output jump_addr,
        output rom_data,
        output instr_ready,
        input  rom_addr,
        input  instr,
        input  instr_pc,
        input  instr_valid
    );

endinterface

// File: rtl/hack_fetch_skid.sv
// rtl/hack_fetch_skid.sv - one-entry skid buffer holding a fetched word and its address
module hack_fetch_skid
    import hack_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  fetch_entry_t load_entry,
    input  logic         drain,
    input  logic         flush,
    output logic         valid,
    output fetch_entry_t entry
);

    // flush discards the held word; load and drain never coincide
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            entry <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            entry <= load_entry;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/hack_fetch.sv
// rtl/hack_fetch.sv - Hack CPU fetch stage: pc, ROM issue, registered output; skid buffer under HACK_FETCH_SKID_EN
module hack_fetch
    import hack_fetch_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    hack_fetch_if.master bus
);

    pc_t          pc;
    logic         inflight;
    pc_t          inflight_pc;
    word_t        instr_q;
    pc_t          instr_pc_q;
    logic         instr_valid_q;

    logic         out_free;
    logic         xfer;
    logic         issue;
    logic         out_load;
    fetch_entry_t out_entry;
    fetch_entry_t ret_entry;
    logic         unused_jump_msb;

    assign unused_jump_msb = bus.jump_addr[WORD_W-1];

`ifdef HACK_FETCH_SKID_EN
    logic         skid_valid;
    fetch_entry_t skid_entry;
    logic         skid_load;
    logic         skid_drain;

    // issue/return steering with the skid buffer absorbing one stalled return
    always_comb begin
        out_free   = !instr_valid_q || bus.instr_ready;
        xfer       = instr_valid_q && bus.instr_ready;
        ret_entry  = '{data: bus.rom_data, pc: inflight_pc};
        issue      = !bus.jump && !skid_valid &&
                     !(inflight && instr_valid_q && !bus.instr_ready);
        skid_drain = !bus.jump && skid_valid && out_free;
        skid_load  = !bus.jump && inflight && !out_free;
        out_load   = !bus.jump && out_free && (skid_valid || inflight);
        out_entry  = skid_valid ? skid_entry : ret_entry;
    end

    hack_fetch_skid u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .load_entry (ret_entry),
        .drain      (skid_drain),
        .flush      (bus.jump),
        .valid      (skid_valid),
        .entry      (skid_entry)
    );
`else
    // issue/return steering without a skid: only issue when the return is sure to land
    always_comb begin
        out_free  = !instr_valid_q || bus.instr_ready;
        xfer      = instr_valid_q && bus.instr_ready;
        ret_entry = '{data: bus.rom_data, pc: inflight_pc};
        issue     = !bus.jump && !inflight && out_free;
        out_load  = !bus.jump && inflight;
        out_entry = ret_entry;
    end
`endif

    // pc, outstanding-read tracking and the output register; jump flushes everything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_PC;
            inflight      <= 1'b0;
            inflight_pc   <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else if (bus.jump) begin
            pc            <= bus.jump_addr[PC_W-1:0];
            inflight      <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc_next(pc);
                inflight_pc <= pc;
            end
            if (out_load) begin
                instr_q       <= out_entry.data;
                instr_pc_q    <= out_entry.pc;
                instr_valid_q <= 1'b1;
            end else if (xfer) begin
                instr_valid_q <= 1'b0;
            end
        end
    end

    assign bus.rom_addr    = pc;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;

endmodule

// File: tb/tb_hack_fetch.sv
// tb/tb_hack_fetch.sv - self-checking bench for hack_fetch with a ROM model and stream scoreboard
module tb_hack_fetch;
    import hack_fetch_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    hack_fetch_if bus ();

    hack_fetch dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef HACK_FETCH_SKID_EN
    localparam int  FIRST_CYCLES   = 4;
    localparam pc_t STALL_ROM_ADDR = 15'd6;
    function automatic bit exp_valid_at(input int i);
        return 1'b1;
    endfunction
    function automatic int exp_pc_at(input int i);
        return i;
    endfunction
`else
    localparam int  FIRST_CYCLES   = 7;
    localparam pc_t STALL_ROM_ADDR = 15'd5;
    function automatic bit exp_valid_at(input int i);
        return (i % 2) == 0;
    endfunction
    function automatic int exp_pc_at(input int i);
        return i / 2;
    endfunction
`endif

    function automatic word_t rom_word(input pc_t a);
        return {1'b0, a} ^ 16'hA5A5;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_data <= rom_word(bus.rom_addr);

    pc_t   exp_pc;
    int    accepted;
    pc_t   acc_q[$];
    bit    prev_stall;
    word_t prev_instr;
    pc_t   prev_ipc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // apply this cycle's checks with the inputs already driven, then advance one clock
    task automatic cycle();
        if (reset) begin
            exp_pc = RESET_PC;
        end else begin
            if (prev_stall) begin
                check("hold_valid", bus.instr_valid, 1);
                check("hold_instr", bus.instr, prev_instr);
                check("hold_pc", bus.instr_pc, prev_ipc);
            end
            if (bus.instr_valid && bus.instr_ready) begin
                check("stream_pc", bus.instr_pc, exp_pc);
                check("stream_instr", bus.instr, rom_word(exp_pc));
                acc_q.push_back(bus.instr_pc);
                accepted++;
                exp_pc = exp_pc + pc_t'(1);
            end
            if (bus.jump) exp_pc = bus.jump_addr[PC_W-1:0];
        end
        prev_stall = !reset && !bus.jump && bus.instr_valid && !bus.instr_ready;
        prev_instr = bus.instr;
        prev_ipc   = bus.instr_pc;
        @(posedge clk);
        #1;
    endtask

    task automatic restart_sequence();
        bus.instr_ready = 1'b1;
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        check("c0_valid", bus.instr_valid, 0);
        check("c0_rom_addr", bus.rom_addr, RESET_PC);
        cycle();
        check("c1_valid", bus.instr_valid, 0);
        cycle();
        for (int i = 0; i < FIRST_CYCLES; i++) begin
            check("first_valid", bus.instr_valid, exp_valid_at(i));
            if (exp_valid_at(i)) begin
                check("first_pc", bus.instr_pc, exp_pc_at(i));
                check("first_instr", bus.instr, rom_word(pc_t'(exp_pc_at(i))));
            end
            cycle();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks          = 0;
        errors          = 0;
        accepted        = 0;
        prev_stall      = 1'b0;
        exp_pc          = RESET_PC;
        reset           = 1'b1;
        bus.jump        = 1'b0;
        bus.jump_addr   = '0;
        bus.instr_ready = 1'b1;
        @(posedge clk);
        #1;

        // out of reset: first word two cycles after release, then steady stream
        restart_sequence();

        // back-pressure at instr_pc 4
        n = 0;
        while (!(bus.instr_valid && bus.instr_pc == 15'd4) && n < 20) begin
            cycle();
            n++;
        end
        check("reach_pc4", bus.instr_pc, 4);
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_rom_addr", bus.rom_addr, STALL_ROM_ADDR);
            check("stall_instr", bus.instr, 16'hA5A1);
            cycle();
        end
        bus.instr_ready = 1'b1;
        acc_q.delete();
        n = 0;
        while (acc_q.size() < 4 && n < 20) begin
            cycle();
            n++;
        end
        check("release_count", acc_q.size(), 4);
        for (int i = 0; i < 4 && i < acc_q.size(); i++)
            check("release_order", acc_q[i], 4 + i);

        // jump while streaming, upper address bit ignored
        cycle();
        cycle();
        bus.jump      = 1'b1;
        bus.jump_addr = 16'h8123;
        cycle();
        bus.jump = 1'b0;
        check("jmp_t1_valid", bus.instr_valid, 0);
        check("jmp_t1_rom_addr", bus.rom_addr, 15'h0123);
        cycle();
        check("jmp_t2_valid", bus.instr_valid, 0);
        cycle();
        check("jmp_t3_valid", bus.instr_valid, 1);
        check("jmp_t3_pc", bus.instr_pc, 15'h0123);
        check("jmp_t3_instr", bus.instr, 16'hA486);
        cycle();

        // wrap at the top of the 15-bit space
        bus.jump      = 1'b1;
        bus.jump_addr = 16'h7FFE;
        cycle();
        bus.jump = 1'b0;
        acc_q.delete();
        n = 0;
        while (acc_q.size() < 4 && n < 20) begin
            cycle();
            n++;
        end
        check("wrap_count", acc_q.size(), 4);
        if (acc_q.size() == 4) begin
            check("wrap_0", acc_q[0], 15'h7FFE);
            check("wrap_1", acc_q[1], 15'h7FFF);
            check("wrap_2", acc_q[2], 15'h0000);
            check("wrap_3", acc_q[3], 15'h0001);
        end

        // reset while stalled with buffered words, then a clean restart
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        reset = 1'b1;
        cycle();
        check("rst_stall_valid", bus.instr_valid, 0);
        check("rst_stall_rom_addr", bus.rom_addr, RESET_PC);
        restart_sequence();

        // random back-pressure with occasional jumps
        accepted = 0;
        for (int i = 0; i < 400; i++) begin
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            bus.jump        = ($urandom_range(0, 39) == 0);
            bus.jump_addr   = 16'($urandom);
            cycle();
        end
        bus.jump = 1'b0;
        check("rand_progress", accepted > 50, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hack_fetch.md
# hack_fetch

Instruction fetch stage of the Hack CPU. It holds the 15-bit program counter, drives the synchronous instruction ROM, and presents fetched instructions to the decode/Mux16 datapath over a valid/ready handshake. The jump target comes in already selected by the upstream Mux16 (A-register value). A registered output plus a one-entry skid buffer give one instruction per cycle under back-pressure.

## Interface
- PC_W, 15, program counter and ROM address width (32K-word ROM)
- WORD_W, 16, instruction width
- RESET_PC, 0, fetch address after reset
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- jump  in  1  redirect fetch to jump_addr this cycle
- jump_addr  in  16  Mux16-selected target; bits [14:0] used, bit 15 ignored
- rom_addr  out  PC_W  ROM read address (equals pc)
- rom_data  in  WORD_W  ROM[rom_addr of previous cycle]; 1-cycle synchronous read
- instr  out  WORD_W  instruction to consumer
- instr_pc  out  PC_W  address of instr
- instr_valid  out  1  instr/instr_pc valid
- instr_ready  in  1  consumer accepts; transfer when instr_valid && instr_ready

## Operation
- State: pc; inflight flag + inflight_pc (ROM read outstanding); output register (instr, instr_pc, instr_valid); skid register (data, pc, valid).
- Issue in cycle t when !jump && !skid_valid && !(inflight && instr_valid && !instr_ready): rom_addr=pc, pc<=pc+1, inflight<=1, inflight_pc<=pc. Otherwise inflight<=0, pc held.
- Return (inflight=1): if output empty or transferring this cycle, output<=rom_data/inflight_pc; else skid<=rom_data/inflight_pc.
- Output empty or transferring while skid_valid: output<=skid, skid_valid<=0 (no issue this cycle, so no return collides).
- pc increment wraps 0x7FFF -> 0x0000, no flag.
- jump=1 (priority over issue/return): pc<=jump_addr[14:0], inflight<=0 (returning data discarded), instr_valid<=0, skid_valid<=0. A transfer occurring in the jump cycle still counts as consumed.
- reset=1: pc<=RESET_PC, inflight, instr_valid, skid_valid <=0; instr, instr_pc <=0; dominates jump.
- rom_addr always equals pc (combinational).

## Timing
- Reset/out-of-reset: reset low in cycle 0 -> rom_addr=RESET_PC issued cycle 0, rom_data cycle 1, instr_valid=1 with ROM[RESET_PC] in cycle 2.
- Jump latency: jump in cycle t -> issue jump_addr cycle t+1 -> instr_valid with ROM[jump_addr] cycle t+3; instr_valid=0 in t+1, t+2.
- Steady state, instr_ready held 1: one instruction per cycle, instr_pc increments by 1.
- instr_ready low: at most one returning word lands in skid; issue stops until skid drains; no word lost or duplicated.
- Outputs stable while instr_valid && !instr_ready.

## Configuration
- HACK_FETCH_SKID_EN defined: skid buffer present, behaviour as above, full throughput.
- Not defined: no skid; issue condition becomes !jump && !inflight && (!instr_valid || instr_ready); throughput one instruction per two cycles; return always lands in output; all other rules (jump, reset, wrap, latencies to first valid) unchanged.

## Structure
- Package hack_fetch_pkg: PC_W, WORD_W, RESET_PC defaults; pc_t (logic [PC_W-1:0]) and word_t typedefs; fetch_entry_t struct {word_t data; pc_t pc;}.
- One sub-module: hack_fetch_skid (one-entry buffer of fetch_entry_t with load/drain/flush), instantiated only under HACK_FETCH_SKID_EN.

## Test plan
ROM model: ROM[i] = i ^ 16'hA5A5.
- Reset 2 cycles, instr_ready=1 -> instr_valid rises cycle 2 after reset release; instr_pc 0,1,2,3 with instr A5A5, A5A4, A5A7, A5A6 on consecutive cycles.
- instr_ready=0 for 5 cycles mid-stream at instr_pc=4 -> instr holds A5A1, rom_addr stops at 6; on release instr_pc 4,5,6,7 back-to-back, no gaps, no repeats.
- jump=1, jump_addr=16'h8123 while streaming -> instr_valid low 2 cycles, then instr_pc=0x0123, instr=0xA486; in-flight word discarded.
- jump_addr=0x7FFE, instr_ready=1 -> instr_pc 7FFE, 7FFF, 0000, 0001 (wrap).
- reset asserted during back-pressure with skid full -> next cycle instr_valid=0, rom_addr=0; restart as first scenario.
- Without HACK_FETCH_SKID_EN, instr_ready=1 -> instr_valid pattern 1,0,1,0; instr_pc 0,1,2 on valid cycles.
